// File: rtl/video_pkg.sv
// video_pkg: shared widths, scanline mode encoding and colour triple for the scanline stage
package video_pkg;
  typedef enum logic [1:0] {SL_OFF = 2'd0, SL_75 = 2'd1, SL_50 = 2'd2, SL_25 = 2'd3} sl_mode_t;
  function automatic int dwidth(input bit half);
    return half ? 3 : 5;
  endfunction
  localparam int DWIDTH = dwidth(1'b0);
  typedef struct packed {
    logic [DWIDTH:0] b;
    logic [DWIDTH:0] g;
    logic [DWIDTH:0] r;
  } colour_t;
endpackage

// File: rtl/scanline_attn.sv
// scanline_attn: combinational per-component brightness reduction for dark scanlines
module scanline_attn
  import video_pkg::*;
#(
  parameter int W = DWIDTH + 1
) (
  input  logic [W-1:0] c,
  input  sl_mode_t     mode,
  input  logic         dark,
  output logic [W-1:0] y
);
  always_comb y = !dark ? c :
                  mode == SL_75 ? c - (c >> 2) :
                  mode == SL_50 ? c >> 1 :
                  mode == SL_25 ? c >> 2 : c;
endmodule

// File: rtl/video_scanlines.sv
// video_scanlines: CRT scanline darkening on scandoubler output with sync/blank kept aligned
// SCANLINES_BLANK_ZERO_EN: force colour to 0 during hblank/vblank
module video_scanlines
  import video_pkg::*;
#(
  parameter bit HALF_DEPTH = 1'b0,
  parameter bit LINE_PHASE = 1'b0,
  localparam int DW = dwidth(HALF_DEPTH)
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [1:0]    scanlines,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  input  logic [DW:0]   r_in,
  input  logic [DW:0]   g_in,
  input  logic [DW:0]   b_in,
  output logic          ce_pix_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic [DW:0]   r_out,
  output logic [DW:0]   g_out,
  output logic [DW:0]   b_out
);
  logic hs_d, vs_d, parity, hs_rise, vs_rise, blank;
  sl_mode_t mode_l, s1_mode;
  colour_t s1_c, a;
  logic s1_hs, s1_vs, s1_hb, s1_vb, s1_dark;
  assign hs_rise = hs_in & ~hs_d;
  assign vs_rise = vs_in & ~vs_d;
`ifdef SCANLINES_BLANK_ZERO_EN
  assign blank = s1_hb | s1_vb;
`else
  assign blank = 1'b0;
`endif
  // line tracking runs every clock so sync edges are never missed between pixels
  always_ff @(posedge clk_vid or posedge reset)
    if (reset) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      parity <= 1'b0;
      mode_l <= SL_OFF;
    end else begin
      hs_d <= hs_in;
      vs_d <= vs_in;
      if (vs_rise) begin
        parity <= 1'b0;
        mode_l <= sl_mode_t'(scanlines);
      end else if (hs_rise)
        parity <= ~parity;
    end
  scanline_attn u_r (.c(s1_c.r), .mode(s1_mode), .dark(s1_dark), .y(a.r));
  scanline_attn u_g (.c(s1_c.g), .mode(s1_mode), .dark(s1_dark), .y(a.g));
  scanline_attn u_b (.c(s1_c.b), .mode(s1_mode), .dark(s1_dark), .y(a.b));
  // mode travels with the pixel so a vsync between S1 and S2 cannot restyle it
  always_ff @(posedge clk_vid or posedge reset)
    if (reset) begin
      s1_c <= '0;
      s1_mode <= SL_OFF;
      {s1_hs, s1_vs, s1_hb, s1_vb, s1_dark} <= '0;
      ce_pix_out <= 1'b0;
      {hs_out, vs_out, hb_out, vb_out} <= '0;
      {r_out, g_out, b_out} <= '0;
    end else begin
      ce_pix_out <= ce_pix;
      if (ce_pix) begin
        s1_c <= '{b: (DWIDTH+1)'(b_in), g: (DWIDTH+1)'(g_in), r: (DWIDTH+1)'(r_in)};
        s1_mode <= mode_l;
        s1_dark <= (parity == LINE_PHASE) && (mode_l != SL_OFF);
        {s1_hs, s1_vs, s1_hb, s1_vb} <= {hs_in, vs_in, hb_in, vb_in};
        {hs_out, vs_out, hb_out, vb_out} <= {s1_hs, s1_vs, s1_hb, s1_vb};
        r_out <= blank ? '0 : a.r[DW:0];
        g_out <= blank ? '0 : a.g[DW:0];
        b_out <= blank ? '0 : a.b[DW:0];
      end
    end
endmodule
